mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 8 x 16 single-port scratch memory.
- Accepts independent read/write requests from two requesters and grants them round-robin.
- Drives the memory's level-sensitive Enable/ReadWrite/Address/DataIn so that address and data are stable before and throughout every enable window.
- Returns read data and a one-cycle acknowledge to the granted requester.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the scratch-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  // Memory ReadWrite polarity
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the scratch-memory arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, ack1, rdata1,
    output mem_enable, mem_read_write, mem_address, mem_data_in, busy
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_enable, mem_read_write, mem_address, mem_data_in, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer for the shared single-port scratch memory.
//   state  | meaning
//   IDLE   | waiting for a request; grant and latch command on exit
//   SETUP  | address/data/direction driven, enable low
//   ACCESS | enable high; read data captured at end of cycle
//   DONE   | enable low, bus still held, ack pulsed to the granted port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  state_t state, state_nxt;

  logic              grant;
  logic              grant_valid;
  logic              last_grant;
  logic              cmd_port;
  logic              enable;
  logic              read_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;

  rr_arb2 u_rr_arb2 (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The memory-side address/data/direction registers double as the command
  // registers: loaded only at grant, held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cmd_port   <= 1'b0;
      enable     <= 1'b0;
      read_write <= READ;
      address    <= '0;
      data_in    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      enable <= (state_nxt == ACCESS);
      busy   <= (state_nxt != IDLE);
      ack0   <= (state == ACCESS) && !cmd_port;
      ack1   <= (state == ACCESS) &&  cmd_port;

      if (state == IDLE && grant_valid) begin
        cmd_port   <= grant;
        last_grant <= grant;
        read_write <= grant ? bus.rw1    : bus.rw0;
        address    <= grant ? bus.addr1  : bus.addr0;
        data_in    <= grant ? bus.wdata1 : bus.wdata0;
      end

      if (state == ACCESS && read_write == READ) begin
        if (cmd_port) begin
          rdata1 <= bus.mem_data_out;
        end else begin
          rdata0 <= bus.mem_data_out;
        end
      end
    end
  end

  assign bus.mem_enable     = enable;
  assign bus.mem_read_write = read_write;
  assign bus.mem_address    = address;
  assign bus.mem_data_in    = data_in;
  assign bus.ack0           = ack0;
  assign bus.ack1           = ack1;
  assign bus.rdata0         = rdata0;
  assign bus.rdata1         = rdata1;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Level-sensitive scratch memory
  logic [15:0] ram [8] = '{default: '0};
  always @(posedge clk)
    if (bus.mem_enable && !bus.mem_read_write) ram[bus.mem_address] <= bus.mem_data_in;
  assign bus.mem_data_out = (bus.mem_enable && bus.mem_read_write) ? ram[bus.mem_address] : 'z;

  typedef struct {
    bit          port;
    bit          rw;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] model_mem [8] = '{default: '0};
  logic [15:0] rdata_model [2];
  bit          last_grant_m;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply a transaction to the reference memory and queue its expected result.
  task automatic push_exp(input bit port, input bit rw, input logic [2:0] addr, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.rw   = rw;
    e.addr = addr;
    if (rw) begin
      e.data = model_mem[addr];
    end else begin
      e.data = data;
      model_mem[addr] = data;
    end
    expq.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    last_grant_m = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // One arbitration round; the second of two simultaneous requesters acks 4 cycles later.
  task automatic run_round(input bit en0, input bit en1, input bit rw0_i, input bit rw1_i,
                           input logic [2:0] a0, input logic [2:0] a1,
                           input logic [15:0] d0, input logic [15:0] d1, input bit scramble);
    int c[2];
    int expc[2];
    int en_mask;
    int want_mask;
    bit first;
    @(posedge clk); #1;
    c[0] = -1; c[1] = -1; expc[0] = -1; expc[1] = -1;
    en_mask = 0;
    if (en0 && en1) begin
      first = last_grant_m ? 1'b0 : 1'b1;
      push_exp(first, first ? rw1_i : rw0_i, first ? a1 : a0, first ? d1 : d0);
      push_exp(!first, first ? rw0_i : rw1_i, first ? a0 : a1, first ? d0 : d1);
      expc[first] = 3;
      expc[!first] = 7;
      last_grant_m = !first;
      want_mask = (1 << 2) | (1 << 6);
    end else begin
      first = en1;
      push_exp(first, first ? rw1_i : rw0_i, first ? a1 : a0, first ? d1 : d0);
      expc[first] = 3;
      last_grant_m = first;
      want_mask = 1 << 2;
    end
    bus.req0 = en0; bus.rw0 = rw0_i; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = en1; bus.rw1 = rw1_i; bus.addr1 = a1; bus.wdata1 = d1;
    for (int cyc = 1; cyc <= 12 && ((en0 && c[0] < 0) || (en1 && c[1] < 0)); cyc++) begin
      @(posedge clk); #1;
      if (bus.mem_enable) en_mask |= (1 << cyc);
      if (scramble && cyc <= 2) begin
        bus.addr0 = 3'($urandom_range(0, 7)); bus.wdata0 = 16'($urandom); bus.rw0 = 1'($urandom);
        bus.addr1 = 3'($urandom_range(0, 7)); bus.wdata1 = 16'($urandom); bus.rw1 = 1'($urandom);
      end
      if (bus.ack0 && c[0] < 0) begin c[0] = cyc; bus.req0 = 1'b0; end
      if (bus.ack1 && c[1] < 0) begin c[1] = cyc; bus.req1 = 1'b0; end
    end
    if (en0) check(c[0] == expc[0], "ack0_latency", c[0], expc[0]);
    if (en1) check(c[1] == expc[1], "ack1_latency", c[1], expc[1]);
    check(en_mask == want_mask, "enable_cycles", en_mask, want_mask);
  endtask

  // Monitor: pops the scoreboard on every ack and checks the memory bus.
  initial begin : monitor
    logic [19:0] prev_bus;
    bit          prev_en;
    exp_t        e;
    prev_en = 1'b0;
    prev_bus = '0;
    rdata_model[0] = '0;
    rdata_model[1] = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        expq.delete();
        rdata_model[0] = '0;
        rdata_model[1] = '0;
        prev_en = 1'b0;
        continue;
      end
      if (bus.mem_enable || prev_en)
        check({bus.mem_address, bus.mem_data_in, bus.mem_read_write} == prev_bus, "bus_stable",
              {bus.mem_address, bus.mem_data_in, bus.mem_read_write}, prev_bus);
      if (bus.mem_enable) begin
        if (expq.size() == 0) begin
          check(1'b0, "enable_without_txn", 1, 0);
        end else begin
          e = expq[0];
          check(bus.mem_address == e.addr, "mem_address", bus.mem_address, e.addr);
          check(bus.mem_read_write == e.rw, "mem_read_write", bus.mem_read_write, e.rw);
          if (!e.rw) check(bus.mem_data_in == e.data, "mem_data_in", bus.mem_data_in, e.data);
        end
      end
      if (bus.ack0 || bus.ack1) begin
        check(!(bus.ack0 && bus.ack1), "ack_both", {bus.ack1, bus.ack0}, 0);
        if (expq.size() == 0) begin
          check(1'b0, "unexpected_ack", {bus.ack1, bus.ack0}, 0);
        end else begin
          e = expq.pop_front();
          check(bus.ack1 == e.port, "ack_port", bus.ack1, e.port);
          if (e.rw) rdata_model[e.port] = e.data;
          check(bus.rdata0 == rdata_model[0], "rdata0", bus.rdata0, rdata_model[0]);
          check(bus.rdata1 == rdata_model[1], "rdata1", bus.rdata1, rdata_model[1]);
        end
      end
      prev_bus = {bus.mem_address, bus.mem_data_in, bus.mem_read_write};
      prev_en = bus.mem_enable;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int a0_mask;
    int a1_mask;
    bus.req0 = 0; bus.rw0 = 1; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.rw1 = 1; bus.addr1 = '0; bus.wdata1 = '0;
    do_reset();

    // Idle after reset
    repeat (5) @(posedge clk);
    #1;
    check(bus.mem_enable == 1'b0, "rst_mem_enable", bus.mem_enable, 0);
    check(bus.busy == 1'b0, "rst_busy", bus.busy, 0);
    check(bus.ack0 == 1'b0, "rst_ack0", bus.ack0, 0);
    check(bus.ack1 == 1'b0, "rst_ack1", bus.ack1, 0);
    check(bus.rdata0 == 16'h0, "rst_rdata0", bus.rdata0, 0);
    check(bus.rdata1 == 16'h0, "rst_rdata1", bus.rdata1, 0);
    check(bus.mem_read_write == 1'b1, "rst_mem_read_write", bus.mem_read_write, 1);
    check(bus.mem_address == 3'd0, "rst_mem_address", bus.mem_address, 0);

    // Write then read back on port 0
    run_round(1, 0, 0, 1, 3'd3, 3'd0, 16'hA5A5, 16'h0, 0);
    run_round(1, 0, 1, 1, 3'd3, 3'd0, 16'h0, 16'h0, 0);
    check(bus.rdata0 == 16'hA5A5, "readback_a5a5", bus.rdata0, 16'hA5A5);

    // Both requesters saturating from reset: grants 0,1,0,1
    do_reset();
    @(posedge clk); #1;
    push_exp(0, 0, 3'd0, 16'd1);
    push_exp(1, 0, 3'd1, 16'd2);
    push_exp(0, 0, 3'd0, 16'd1);
    push_exp(1, 0, 3'd1, 16'd2);
    last_grant_m = 1'b1;
    bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 3'd0; bus.wdata0 = 16'd1;
    bus.req1 = 1; bus.rw1 = 0; bus.addr1 = 3'd1; bus.wdata1 = 16'd2;
    a0_mask = 0;
    a1_mask = 0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk); #1;
      if (bus.ack0) a0_mask |= (1 << cyc);
      if (bus.ack1) a1_mask |= (1 << cyc);
    end
    bus.req0 = 0;
    bus.req1 = 0;
    check(a0_mask == ((1 << 3) | (1 << 11)), "sat_ack0_cycles", a0_mask, (1 << 3) | (1 << 11));
    check(a1_mask == ((1 << 7) | (1 << 15)), "sat_ack1_cycles", a1_mask, (1 << 7) | (1 << 15));

    // Port 1 writes, port 0 reads it back; rdata1 untouched
    run_round(0, 1, 1, 0, 3'd0, 3'd7, 16'h0, 16'h1234, 0);
    run_round(1, 0, 1, 1, 3'd7, 3'd0, 16'h0, 16'h0, 0);
    check(bus.rdata0 == 16'h1234, "cross_read", bus.rdata0, 16'h1234);

    // Command inputs changed after grant must not reach the memory
    run_round(1, 0, 0, 1, 3'd5, 3'd0, 16'hBEEF, 16'h0, 1);
    run_round(0, 1, 0, 1, 3'd0, 3'd6, 16'h0, 16'hCAFE, 1);
    run_round(1, 0, 1, 1, 3'd5, 3'd0, 16'h0, 16'h0, 1);

    // Reset during ACCESS of a read
    @(posedge clk); #1;
    push_exp(0, 1, 3'd5, 16'h0);
    bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    check(bus.mem_enable == 1'b1, "abort_in_access", bus.mem_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check(bus.mem_enable == 1'b0, "abort_enable_drop", bus.mem_enable, 0);
    check(bus.busy == 1'b0, "abort_busy", bus.busy, 0);
    check(bus.ack0 == 1'b0, "abort_ack0", bus.ack0, 0);
    check(bus.rdata0 == 16'h0, "abort_rdata0", bus.rdata0, 0);
    bus.req0 = 0;
    last_grant_m = 1'b1;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_round(1, 0, 1, 1, 3'd5, 3'd0, 16'h0, 16'h0, 0);
    check(bus.rdata0 == 16'hBEEF, "post_reset_read", bus.rdata0, 16'hBEEF);

    // Randomized rounds
    for (int i = 0; i < 80; i++) begin
      int sel;
      bit single;
      sel = $urandom_range(1, 3);
      single = (sel != 3);
      run_round(sel[0], sel[1], 1'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                16'($urandom), 16'($urandom), single && 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check(expq.size() == 0, "scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
